// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies LEN words src->dst over the data memory port, one read then one write per word.
// Optional build macro MEMCOPY_CHECKSUM_EN adds a checksum output summing every word written.
module mem_copy_engine #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              MemRead,
    output logic              MemWrite
`ifdef MEMCOPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    state_t            state_q;
    logic [ADDR_W-1:0] src_q, dst_q, addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [DATA_W-1:0] buf_q;
    logic              busy_q, done_q, rd_q, wr_q;
    logic [LEN_W-1:0]  len_clamped;
`ifdef MEMCOPY_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
`endif

    // Requests longer than the whole memory are cut to one full pass.
    always_comb len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

    // Copy FSM; all port outputs are registered and set on the edge entering each state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef MEMCOPY_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    src_q <= src_addr;
                    dst_q <= dst_addr;
                    rem_q <= len_clamped;
`ifdef MEMCOPY_CHECKSUM_EN
                    csum_q <= '0;
`endif
                    if (len_clamped == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= READ;
                        busy_q  <= 1'b1;
                        rd_q    <= 1'b1;
                        addr_q  <= src_addr;
                    end
                end
                READ: begin
                    rd_q <= 1'b0;
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        buf_q   <= read_data;
                        state_q <= WRITE;
                        wr_q    <= 1'b1;
                        addr_q  <= dst_q;
                    end
                end
                WRITE: begin
                    wr_q  <= 1'b0;
                    src_q <= src_q + 1'b1;
                    dst_q <= dst_q + 1'b1;
                    rem_q <= rem_q - 1'b1;
`ifdef MEMCOPY_CHECKSUM_EN
                    csum_q <= csum_q + buf_q;
`endif
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (rem_q == LEN_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= READ;
                        rd_q    <= 1'b1;
                        addr_q  <= src_q + 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign addr       = addr_q;
    assign write_data = buf_q;
    assign MemRead    = rd_q;
    assign MemWrite   = wr_q;
`ifdef MEMCOPY_CHECKSUM_EN
    assign checksum   = csum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed vector table plus reset/abort sequences against a 128x32 memory model.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [6:0]  src_addr = '0;
    logic [6:0]  dst_addr = '0;
    logic [7:0]  length = '0;
    logic        busy, done, MemRead, MemWrite;
    logic [6:0]  addr;
    logic [31:0] write_data, read_data;
`ifdef MEMCOPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem [128];
    int compared = 0;
    int mismatched = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    bit both_seen = 0;

    typedef struct {
        logic [6:0]        src;
        logic [6:0]        dst;
        logic [7:0]        len;
        int                cyc;
        int                nwr;
        logic [31:0]       ck;
        logic [0:3][6:0]   a;
        logic [0:3][31:0]  d;
    } vec_t;

    vec_t vecs [6];

    mem_copy_engine dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .addr(addr), .write_data(write_data),
        .read_data(read_data), .MemRead(MemRead), .MemWrite(MemWrite)
`ifdef MEMCOPY_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    assign read_data = MemRead ? mem[addr] : 32'd0;

    always @(posedge clk) if (MemWrite) mem[addr] <= write_data;

    always @(negedge clk) begin
        if (MemWrite) wr_cnt++;
        if (done) done_cnt++;
        if (MemRead && MemWrite) both_seen = 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic preload();
        logic [31:0] init_v [10] = '{5, 1, 3, 2, 8, 12, 4, 19, 6, 3};
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        for (int i = 0; i < 10; i++) mem[i] = init_v[i];
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        preload();
        wr_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic run_copy(input vec_t v);
        int k;
        do_reset();
        src_addr = v.src;
        dst_addr = v.dst;
        length = v.len;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", busy, v.nwr != 0);
        k = 1;
        while (!done && k < 600) begin
            @(posedge clk);
            #1 k++;
        end
        check("latency", k, v.cyc);
        check("busy_at_done", busy, 0);
        @(posedge clk);
        #1 check("done_one_cycle", done, 0);
        check("write_count", wr_cnt, v.nwr);
        for (int j = 0; j < 4; j++) check($sformatf("mem[%0d]", v.a[j]), mem[v.a[j]], v.d[j]);
`ifdef MEMCOPY_CHECKSUM_EN
        check("checksum", checksum, v.ck);
`endif
    endtask

    initial begin
        vecs[0] = '{7'd0,  7'd20,  8'd4,   9,   4,   32'd11, {7'd20, 7'd21, 7'd22, 7'd23}, {32'd5, 32'd1, 32'd3, 32'd2}};
        vecs[1] = '{7'd0,  7'd20,  8'd0,   1,   0,   32'd0,  {7'd20, 7'd0, 7'd1, 7'd2},    {32'd0, 32'd5, 32'd1, 32'd3}};
        vecs[2] = '{7'd8,  7'd126, 8'd3,   7,   3,   32'd9,  {7'd126, 7'd127, 7'd0, 7'd1}, {32'd6, 32'd3, 32'd0, 32'd1}};
        vecs[3] = '{7'd0,  7'd1,   8'd3,   7,   3,   32'd15, {7'd0, 7'd1, 7'd2, 7'd3},     {32'd5, 32'd5, 32'd5, 32'd5}};
        vecs[4] = '{7'd0,  7'd0,   8'd200, 257, 128, 32'd63, {7'd0, 7'd7, 7'd9, 7'd127},   {32'd5, 32'd19, 32'd3, 32'd0}};
        vecs[5] = '{7'd9,  7'd10,  8'd1,   3,   1,   32'd3,  {7'd10, 7'd9, 7'd11, 7'd8},   {32'd3, 32'd3, 32'd0, 32'd6}};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_memread", MemRead, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", write_data, 0);
`ifdef MEMCOPY_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif

        for (int i = 0; i < 6; i++) run_copy(vecs[i]);

        // reset asserted mid-copy, right after the second WRITE edge
        do_reset();
        src_addr = 7'd4; dst_addr = 7'd40; length = 8'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_memread", MemRead, 0);
        check("midrst_memwrite", MemWrite, 0);
        check("midrst_addr", addr, 0);
        check("midrst_wdata", write_data, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_done_cnt", done_cnt, 0);
        check("midrst_mem40", mem[40], 8);
        check("midrst_mem41", mem[41], 12);
        check("midrst_mem42", mem[42], 0);
        check("midrst_mem43", mem[43], 0);

        // start pulsed while busy, then abort in the third READ
        do_reset();
        src_addr = 7'd0; dst_addr = 7'd60; length = 8'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check("wr_strobe", MemWrite, 1);
        check("wr_addr", addr, 60);
        check("wr_data", write_data, 5);
        src_addr = 7'd7; dst_addr = 7'd61; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_ignores_start", busy, 1);
        check("rd_addr_2", addr, 1);
        repeat (2) @(posedge clk);
        #1;
        check("third_read", MemRead, 1);
        check("third_read_addr", addr, 2);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_memread", MemRead, 0);
        check("abort_memwrite", MemWrite, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_done_cnt", done_cnt, 0);
        check("abort_mem60", mem[60], 5);
        check("abort_mem61", mem[61], 1);
        check("abort_mem62", mem[62], 0);

        // start and abort together in IDLE: start wins
        src_addr = 7'd9; dst_addr = 7'd70; length = 8'd1; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        check("startwins_read", MemRead, 1);
        repeat (2) @(posedge clk);
        #1;
        check("startwins_done", done, 1);
        @(posedge clk);
        #1 check("startwins_mem70", mem[70], 3);

        check("rd_wr_exclusive", both_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
